// File: rtl/xif_copro_issue_queue.sv
// XIF coprocessor issue/commit front end: decodes offloaded instructions, queues them in
// program order with their operands, and dispatches each once the core commits it.
module xif_copro_issue_queue #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned XLEN       = 32,
   parameter bit          ENABLE_ROT = 1'b1
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        issue_valid_i,
   output logic                        issue_ready_o,
   input  logic [31:0]                 issue_instr_i,
   input  logic [ID_WIDTH-1:0]         issue_id_i,
   input  logic [1:0][XLEN-1:0]        issue_rs_i,
   input  logic [1:0]                  issue_rs_valid_i,
   output logic                        issue_accept_o,
   output logic                        issue_writeback_o,
   input  logic                        commit_valid_i,
   input  logic [ID_WIDTH-1:0]         commit_id_i,
   input  logic                        commit_kill_i,
   output logic                        ex_valid_o,
   input  logic                        ex_ready_i,
   output logic [1:0]                  ex_op_o,
   output logic [ID_WIDTH-1:0]         ex_id_o,
   output logic [XLEN-1:0]             ex_rs1_o,
   output logic [XLEN-1:0]             ex_rs2_o,
   output logic [$clog2(DEPTH):0]      count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;
   localparam logic [1:0] OP_BITREV      = 2'd0;
   localparam logic [1:0] OP_ROTRIGHT    = 2'd1;
   localparam logic [1:0] OP_ROTLEFT     = 2'd2;

   typedef enum logic [1:0] {
      E_FREE      = 2'd0,
      E_PENDING   = 2'd1,
      E_COMMITTED = 2'd2,
      E_KILLED    = 2'd3
   } entry_state_e;

   entry_state_e            state_q [DEPTH];
   logic [1:0]              op_q    [DEPTH];
   logic [ID_WIDTH-1:0]     id_q    [DEPTH];
   logic [XLEN-1:0]         rs1_q   [DEPTH];
   logic [XLEN-1:0]         rs2_q   [DEPTH];
   logic [PW-1:0]           head_q, tail_q, cptr_q;
   logic [CW-1:0]           count_q;

   logic                    dec_legal, dec_need_rs2;
   logic [1:0]              dec_op;
   logic                    full, issue_hs, has_pending;
   logic                    commit_old, commit_new, head_free;
   entry_state_e            commit_state;

   // Register/immediate fields are irrelevant to these ops.
   logic unused_instr_bits;
   assign unused_instr_bits = ^{issue_instr_i[24:15], issue_instr_i[11:7]};

   always_comb begin
      dec_legal    = 1'b0;
      dec_need_rs2 = 1'b0;
      dec_op       = OP_BITREV;
      if (issue_instr_i[6:0] == OPCODE_CUSTOM0 && issue_instr_i[14:12] == 3'b000) begin
         case (issue_instr_i[31:25])
            7'h00: begin
               dec_legal = 1'b1;
               dec_op    = OP_BITREV;
            end
            7'h01: begin
               dec_legal    = ENABLE_ROT;
               dec_need_rs2 = 1'b1;
               dec_op       = OP_ROTRIGHT;
            end
            7'h02: begin
               dec_legal    = ENABLE_ROT;
               dec_need_rs2 = 1'b1;
               dec_op       = OP_ROTLEFT;
            end
            default: dec_legal = 1'b0;
         endcase
      end
   end

   // Full blocks issue even when the head frees in the same cycle.
   assign full              = (count_q == CW'(DEPTH));
   assign issue_accept_o    = dec_legal;
   assign issue_writeback_o = dec_legal;
   assign issue_ready_o     = !dec_legal ||
                              (!full && issue_rs_valid_i[0] && (!dec_need_rs2 || issue_rs_valid_i[1]));
   assign issue_hs          = issue_valid_i && dec_legal && issue_ready_o;

   // Pending entries live in [cptr, tail); with none pending cptr == tail, so a
   // commit for the instruction being issued right now lands on the new entry.
   assign has_pending  = (state_q[cptr_q] == E_PENDING);
   assign commit_old   = commit_valid_i && has_pending && (id_q[cptr_q] == commit_id_i);
   assign commit_new   = commit_valid_i && !has_pending && issue_hs && (issue_id_i == commit_id_i);
   assign commit_state = commit_kill_i ? E_KILLED : E_COMMITTED;

   assign ex_valid_o = (state_q[head_q] == E_COMMITTED);
   assign head_free  = (ex_valid_o && ex_ready_i) || (state_q[head_q] == E_KILLED);
   assign ex_op_o    = op_q[head_q];
   assign ex_id_o    = id_q[head_q];
   assign ex_rs1_o   = rs1_q[head_q];
   assign ex_rs2_o   = rs2_q[head_q];
   assign count_o    = count_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            state_q[i] <= E_FREE;
            op_q[i]    <= '0;
            id_q[i]    <= '0;
            rs1_q[i]   <= '0;
            rs2_q[i]   <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         cptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (issue_hs) begin
            op_q[tail_q]    <= dec_op;
            id_q[tail_q]    <= issue_id_i;
            rs1_q[tail_q]   <= issue_rs_i[0];
            rs2_q[tail_q]   <= issue_rs_i[1];
            state_q[tail_q] <= commit_new ? commit_state : E_PENDING;
            tail_q          <= tail_q + 1'b1;
         end
         if (commit_old) begin
            state_q[cptr_q] <= commit_state;
         end
         if (commit_old || commit_new) begin
            cptr_q <= cptr_q + 1'b1;
         end
         // Head never aliases tail or cptr here: enqueue needs !full, cptr entries are PENDING.
         if (head_free) begin
            state_q[head_q] <= E_FREE;
            head_q          <= head_q + 1'b1;
         end
         case ({issue_hs, head_free})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_xif_copro_issue_queue.sv
// Directed bench for xif_copro_issue_queue: one task per scenario with inline checks,
// plus a second instance built without rotate ops.
module tb_xif_copro_issue_queue;

   localparam int DEPTH = 4;
   localparam int IDW   = 4;
   localparam int XLEN  = 32;

   localparam logic [31:0] I_BITREV  = 32'h0000_008B;
   localparam logic [31:0] I_ROTR    = 32'h0200_008B;
   localparam logic [31:0] I_ROTL    = 32'h0400_008B;
   localparam logic [31:0] I_ILLEGAL = 32'h0000_0013;

   logic                  clk, rst_n;
   logic                  issue_valid;
   logic [31:0]           issue_instr;
   logic [IDW-1:0]        issue_id;
   logic [1:0][XLEN-1:0]  issue_rs;
   logic [1:0]            issue_rs_valid;
   logic                  commit_valid, commit_kill, ex_ready;
   logic [IDW-1:0]        commit_id;

   logic                  issue_ready, issue_accept, issue_wb, ex_valid;
   logic [1:0]            ex_op;
   logic [IDW-1:0]        ex_id;
   logic [XLEN-1:0]       ex_rs1, ex_rs2;
   logic [2:0]            count;

   logic                  nr_issue_ready, nr_issue_accept, nr_issue_wb, nr_ex_valid;
   logic [1:0]            nr_ex_op;
   logic [IDW-1:0]        nr_ex_id;
   logic [XLEN-1:0]       nr_ex_rs1, nr_ex_rs2;
   logic [2:0]            nr_count;

   int checks   = 0;
   int failures = 0;

   xif_copro_issue_queue #(.DEPTH(DEPTH), .ID_WIDTH(IDW), .XLEN(XLEN), .ENABLE_ROT(1'b1)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_instr_i(issue_instr),
      .issue_id_i(issue_id), .issue_rs_i(issue_rs), .issue_rs_valid_i(issue_rs_valid),
      .issue_accept_o(issue_accept), .issue_writeback_o(issue_wb),
      .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
      .ex_valid_o(ex_valid), .ex_ready_i(ex_ready), .ex_op_o(ex_op), .ex_id_o(ex_id),
      .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2), .count_o(count)
   );

   xif_copro_issue_queue #(.DEPTH(DEPTH), .ID_WIDTH(IDW), .XLEN(XLEN), .ENABLE_ROT(1'b0)) dut_norot (
      .clk_i(clk), .rst_ni(rst_n),
      .issue_valid_i(issue_valid), .issue_ready_o(nr_issue_ready), .issue_instr_i(issue_instr),
      .issue_id_i(issue_id), .issue_rs_i(issue_rs), .issue_rs_valid_i(issue_rs_valid),
      .issue_accept_o(nr_issue_accept), .issue_writeback_o(nr_issue_wb),
      .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
      .ex_valid_o(nr_ex_valid), .ex_ready_i(ex_ready), .ex_op_o(nr_ex_op), .ex_id_o(nr_ex_id),
      .ex_rs1_o(nr_ex_rs1), .ex_rs2_o(nr_ex_rs2), .count_o(nr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      issue_valid    = 1'b0;
      issue_instr    = 32'h0;
      issue_id       = '0;
      issue_rs       = '0;
      issue_rs_valid = 2'b00;
      commit_valid   = 1'b0;
      commit_id      = '0;
      commit_kill    = 1'b0;
   endtask

   task automatic drive_issue(input logic [31:0] instr, input logic [IDW-1:0] id,
                              input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                              input logic [1:0] vld);
      issue_valid    = 1'b1;
      issue_instr    = instr;
      issue_id       = id;
      issue_rs[0]    = rs1;
      issue_rs[1]    = rs2;
      issue_rs_valid = vld;
   endtask

   task automatic drive_commit(input logic [IDW-1:0] id, input logic kill);
      commit_valid = 1'b1;
      commit_id    = id;
      commit_kill  = kill;
   endtask

   task automatic test_reset();
      drive_idle();
      ex_ready = 1'b0;
      rst_n    = 1'b0;
      tick();
      tick();
      checks += 6;
      if (count !== 3'd0)      begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
      if (ex_valid !== 1'b0)   begin failures++; $display("FAIL reset_ex_valid: got %0b expected 0", ex_valid); end
      if (ex_op !== 2'd0)      begin failures++; $display("FAIL reset_ex_op: got %0d expected 0", ex_op); end
      if (ex_id !== 4'd0)      begin failures++; $display("FAIL reset_ex_id: got %0d expected 0", ex_id); end
      if (ex_rs1 !== 32'h0)    begin failures++; $display("FAIL reset_ex_rs1: got %0h expected 0", ex_rs1); end
      if (ex_rs2 !== 32'h0)    begin failures++; $display("FAIL reset_ex_rs2: got %0h expected 0", ex_rs2); end
      drive_issue(I_BITREV, 4'd0, 32'h0, 32'h0, 2'b11);
      #1;
      checks++;
      if (issue_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b expected 1", issue_ready); end
      drive_idle();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_bitrev();
      drive_issue(I_BITREV, 4'd3, 32'h0000_0001, 32'h0, 2'b01);
      drive_commit(4'd3, 1'b0);
      #1;
      checks += 3;
      if (issue_accept !== 1'b1) begin failures++; $display("FAIL bitrev_accept: got %0b expected 1", issue_accept); end
      if (issue_wb !== 1'b1)     begin failures++; $display("FAIL bitrev_writeback: got %0b expected 1", issue_wb); end
      if (issue_ready !== 1'b1)  begin failures++; $display("FAIL bitrev_ready: got %0b expected 1", issue_ready); end
      tick();
      drive_idle();
      checks += 5;
      if (ex_valid !== 1'b1)     begin failures++; $display("FAIL bitrev_ex_valid: got %0b expected 1", ex_valid); end
      if (ex_op !== 2'd0)        begin failures++; $display("FAIL bitrev_ex_op: got %0d expected 0", ex_op); end
      if (ex_id !== 4'd3)        begin failures++; $display("FAIL bitrev_ex_id: got %0d expected 3", ex_id); end
      if (ex_rs1 !== 32'h1)      begin failures++; $display("FAIL bitrev_ex_rs1: got %0h expected 1", ex_rs1); end
      if (count !== 3'd1)        begin failures++; $display("FAIL bitrev_count: got %0d expected 1", count); end
      ex_ready = 1'b1;
      tick();
      ex_ready = 1'b0;
      checks += 2;
      if (ex_valid !== 1'b0)     begin failures++; $display("FAIL bitrev_drain_valid: got %0b expected 0", ex_valid); end
      if (count !== 3'd0)        begin failures++; $display("FAIL bitrev_drain_count: got %0d expected 0", count); end
   endtask

   task automatic test_illegal();
      drive_issue(I_ILLEGAL, 4'd2, 32'h5, 32'h6, 2'b11);
      #1;
      checks += 3;
      if (issue_ready !== 1'b1)  begin failures++; $display("FAIL illegal_ready: got %0b expected 1", issue_ready); end
      if (issue_accept !== 1'b0) begin failures++; $display("FAIL illegal_accept: got %0b expected 0", issue_accept); end
      if (issue_wb !== 1'b0)     begin failures++; $display("FAIL illegal_writeback: got %0b expected 0", issue_wb); end
      tick();
      drive_idle();
      checks++;
      if (count !== 3'd0)        begin failures++; $display("FAIL illegal_count: got %0d expected 0", count); end
   endtask

   task automatic test_rot();
      drive_issue(I_ROTL, 4'd6, 32'h1, 32'h1, 2'b11);
      #1;
      checks += 3;
      if (nr_issue_accept !== 1'b0) begin failures++; $display("FAIL norot_rotl_accept: got %0b expected 0", nr_issue_accept); end
      if (nr_issue_ready !== 1'b1)  begin failures++; $display("FAIL norot_rotl_ready: got %0b expected 1", nr_issue_ready); end
      if (issue_accept !== 1'b1)    begin failures++; $display("FAIL rot_rotl_accept: got %0b expected 1", issue_accept); end
      drive_issue(I_ROTR, 4'd5, 32'h8000_0001, 32'd4, 2'b01);
      #1;
      checks++;
      if (issue_ready !== 1'b0)     begin failures++; $display("FAIL rotr_ready_rs2_missing: got %0b expected 0", issue_ready); end
      tick();
      checks++;
      if (count !== 3'd0)           begin failures++; $display("FAIL rotr_no_enqueue: got %0d expected 0", count); end
      issue_rs_valid = 2'b11;
      #1;
      checks++;
      if (issue_ready !== 1'b1)     begin failures++; $display("FAIL rotr_ready_rs_ok: got %0b expected 1", issue_ready); end
      tick();
      drive_idle();
      checks += 2;
      if (count !== 3'd1)           begin failures++; $display("FAIL rotr_count: got %0d expected 1", count); end
      if (ex_valid !== 1'b0)        begin failures++; $display("FAIL rotr_uncommitted_valid: got %0b expected 0", ex_valid); end
      drive_commit(4'd5, 1'b0);
      tick();
      drive_idle();
      checks += 4;
      if (ex_valid !== 1'b1)        begin failures++; $display("FAIL rotr_ex_valid: got %0b expected 1", ex_valid); end
      if (ex_op !== 2'd1)           begin failures++; $display("FAIL rotr_ex_op: got %0d expected 1", ex_op); end
      if (ex_rs1 !== 32'h8000_0001) begin failures++; $display("FAIL rotr_ex_rs1: got %0h expected 80000001", ex_rs1); end
      if (ex_rs2 !== 32'd4)         begin failures++; $display("FAIL rotr_ex_rs2: got %0h expected 4", ex_rs2); end
      ex_ready = 1'b1;
      tick();
      ex_ready = 1'b0;
      checks++;
      if (count !== 3'd0)           begin failures++; $display("FAIL rotr_drain_count: got %0d expected 0", count); end
   endtask

   task automatic test_full();
      for (int i = 0; i < DEPTH; i++) begin
         drive_issue(I_BITREV, IDW'(i), 32'h100 + 32'(i), 32'h0, 2'b01);
         tick();
      end
      drive_idle();
      checks++;
      if (count !== 3'd4)          begin failures++; $display("FAIL full_count: got %0d expected 4", count); end
      drive_issue(I_BITREV, 4'd4, 32'h104, 32'h0, 2'b01);
      #1;
      checks++;
      if (issue_ready !== 1'b0)    begin failures++; $display("FAIL full_ready: got %0b expected 0", issue_ready); end
      tick();
      drive_idle();
      checks++;
      if (count !== 3'd4)          begin failures++; $display("FAIL full_no_enqueue: got %0d expected 4", count); end
      drive_commit(4'd0, 1'b0);
      ex_ready = 1'b1;
      tick();
      drive_idle();
      issue_instr    = I_BITREV;
      issue_rs_valid = 2'b01;
      #1;
      checks += 3;
      if (ex_valid !== 1'b1 || ex_id !== 4'd0) begin
         failures++; $display("FAIL full_head_dispatch: got valid=%0b id=%0d expected valid=1 id=0", ex_valid, ex_id);
      end
      if (ex_rs1 !== 32'h100)      begin failures++; $display("FAIL full_head_rs1: got %0h expected 100", ex_rs1); end
      if (issue_ready !== 1'b0)    begin failures++; $display("FAIL full_ready_while_freeing: got %0b expected 0", issue_ready); end
      tick();
      checks += 2;
      if (count !== 3'd3)          begin failures++; $display("FAIL full_freed_count: got %0d expected 3", count); end
      if (issue_ready !== 1'b1)    begin failures++; $display("FAIL full_freed_ready: got %0b expected 1", issue_ready); end
      for (int i = 1; i < DEPTH; i++) begin
         drive_commit(IDW'(i), 1'b1);
         tick();
      end
      drive_idle();
      tick();
      ex_ready = 1'b0;
      checks += 2;
      if (count !== 3'd0)          begin failures++; $display("FAIL full_kill_drain_count: got %0d expected 0", count); end
      if (ex_valid !== 1'b0)       begin failures++; $display("FAIL full_kill_drain_valid: got %0b expected 0", ex_valid); end
   endtask

   task automatic test_kill();
      drive_issue(I_BITREV, 4'd1, 32'h11, 32'h0, 2'b01);
      tick();
      drive_issue(I_BITREV, 4'd2, 32'h22, 32'h0, 2'b01);
      tick();
      drive_idle();
      drive_commit(4'd1, 1'b1);
      tick();
      drive_idle();
      checks++;
      if (ex_valid !== 1'b0)   begin failures++; $display("FAIL kill_head_valid: got %0b id=%0d expected 0", ex_valid, ex_id); end
      drive_commit(4'd2, 1'b0);
      tick();
      drive_idle();
      checks += 3;
      if (ex_valid !== 1'b1)   begin failures++; $display("FAIL kill_next_valid: got %0b expected 1", ex_valid); end
      if (ex_id !== 4'd2)      begin failures++; $display("FAIL kill_next_id: got %0d expected 2", ex_id); end
      if (ex_rs1 !== 32'h22)   begin failures++; $display("FAIL kill_next_rs1: got %0h expected 22", ex_rs1); end
      ex_ready = 1'b1;
      tick();
      ex_ready = 1'b0;
      checks++;
      if (count !== 3'd0)      begin failures++; $display("FAIL kill_drain_count: got %0d expected 0", count); end
   endtask

   task automatic test_ignore_and_stall();
      drive_issue(I_BITREV, 4'd5, 32'hA5A5_0000, 32'h0, 2'b01);
      tick();
      drive_idle();
      drive_commit(4'd7, 1'b0);
      tick();
      drive_idle();
      checks += 2;
      if (ex_valid !== 1'b0)   begin failures++; $display("FAIL ignore_valid: got %0b expected 0", ex_valid); end
      if (count !== 3'd1)      begin failures++; $display("FAIL ignore_count: got %0d expected 1", count); end
      drive_commit(4'd5, 1'b0);
      tick();
      drive_idle();
      ex_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (ex_valid !== 1'b1 || ex_id !== 4'd5 || ex_rs1 !== 32'hA5A5_0000 || ex_op !== 2'd0) begin
            failures++;
            $display("FAIL stall_hold_%0d: got valid=%0b id=%0d rs1=%0h op=%0d expected valid=1 id=5 rs1=a5a50000 op=0",
                     k, ex_valid, ex_id, ex_rs1, ex_op);
         end
         tick();
      end
      ex_ready = 1'b1;
      tick();
      ex_ready = 1'b0;
      checks++;
      if (count !== 3'd0)      begin failures++; $display("FAIL stall_drain_count: got %0d expected 0", count); end
   endtask

   task automatic test_back_to_back();
      ex_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive_issue(I_BITREV, IDW'(8 + k), 32'h1000 + 32'(k), 32'h0, 2'b01);
         drive_commit(IDW'(8 + k), 1'b0);
         tick();
         checks++;
         if (ex_valid !== 1'b1 || ex_id !== IDW'(8 + k) || ex_rs1 !== 32'h1000 + 32'(k) || count !== 3'd1) begin
            failures++;
            $display("FAIL b2b_%0d: got valid=%0b id=%0d rs1=%0h count=%0d expected valid=1 id=%0d rs1=%0h count=1",
                     k, ex_valid, ex_id, ex_rs1, count, 8 + k, 32'h1000 + 32'(k));
         end
      end
      drive_idle();
      tick();
      ex_ready = 1'b0;
      checks++;
      if (count !== 3'd0 || ex_valid !== 1'b0) begin
         failures++; $display("FAIL b2b_drain: got count=%0d valid=%0b expected count=0 valid=0", count, ex_valid);
      end
   endtask

   task automatic test_reset_mid();
      drive_issue(I_BITREV, 4'd1, 32'h31, 32'h0, 2'b01);
      drive_commit(4'd1, 1'b0);
      tick();
      drive_issue(I_BITREV, 4'd2, 32'h32, 32'h0, 2'b01);
      tick();
      drive_idle();
      checks++;
      if (count !== 3'd2 || ex_valid !== 1'b1) begin
         failures++; $display("FAIL rstmid_pre: got count=%0d valid=%0b expected count=2 valid=1", count, ex_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (count !== 3'd0 || ex_valid !== 1'b0) begin
         failures++; $display("FAIL rstmid_async: got count=%0d valid=%0b expected count=0 valid=0", count, ex_valid);
      end
      tick();
      rst_n    = 1'b1;
      ex_ready = 1'b1;
      tick();
      tick();
      ex_ready = 1'b0;
      checks++;
      if (count !== 3'd0 || ex_valid !== 1'b0) begin
         failures++; $display("FAIL rstmid_after: got count=%0d valid=%0b expected count=0 valid=0", count, ex_valid);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      ex_ready = 1'b0;
      drive_idle();
      test_reset();
      test_bitrev();
      test_illegal();
      test_rot();
      test_full();
      test_kill();
      test_ignore_and_stall();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/xif_copro_issue_queue.md
# xif_copro_issue_queue

Parametrised issue/commit front end for the XIF coprocessor: it decodes offloaded instructions on the XIF issue interface, buffers accepted operations with their source operands in a DEPTH-entry in-order queue, and holds each entry until the core commits or kills it. Committed operations are dispatched in program order to the coprocessor execute stage over a valid/ready handshake. It is the successor to the purely combinational decoder: queueing, commit tracking and a configurable op set are new.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- ID_WIDTH, 4: XIF instruction id width.
- XLEN, 32: operand width.
- ENABLE_ROT, 1: 1 decodes ROTRIGHT/ROTLEFT; 0 rejects them.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- issue_valid_i  in  1  issue request.
- issue_ready_o  out  1  issue handshake ready (combinational).
- issue_instr_i  in  32  offloaded instruction.
- issue_id_i  in  ID_WIDTH  instruction id.
- issue_rs_i  in  2×XLEN  rs1 (index 0), rs2 (index 1).
- issue_rs_valid_i  in  2  operand valid flags.
- issue_accept_o  out  1  instruction is a coprocessor op (combinational).
- issue_writeback_o  out  1  equals issue_accept_o; result goes to a CPU GPR.
- commit_valid_i  in  1  commit strobe.
- commit_id_i  in  ID_WIDTH  id being committed.
- commit_kill_i  in  1  1 = discard, 0 = execute.
- ex_valid_o  out  1  head entry ready to execute.
- ex_ready_i  in  1  execute stage accepts.
- ex_op_o  out  2  0 BITREV, 1 ROTRIGHT, 2 ROTLEFT.
- ex_id_o  out  ID_WIDTH  id of dispatched op.
- ex_rs1_o, ex_rs2_o  out  XLEN  operands.
- count_o  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Decode: opcode 7'b0001011, funct3 3'b000; funct7 7'h00 BITREV (needs rs1), 7'h01 ROTRIGHT, 7'h02 ROTLEFT (need rs1, rs2). Anything else is illegal (accept=0).
- Illegal instr: issue_ready_o=1, accept=0, nothing enqueued.
- Legal instr: issue_ready_o = !full && all required rs_valid bits set. Handshake (valid&&ready) writes entry {op, id, rs1, rs2, state=PENDING} at tail; tail wraps modulo DEPTH.
- Entry states: FREE → PENDING (issued) → COMMITTED or KILLED → FREE.
- Commit: applies only when commit_id_i equals id of the oldest PENDING entry (commit pointer); otherwise ignored (covers commits of rejected ids). kill=0 → COMMITTED, kill=1 → KILLED; commit pointer advances.
- Commit in the same cycle as that instruction's issue handshake (queue holds no PENDING entry): applied to the new entry, which is written directly as COMMITTED/KILLED.
- Dispatch: ex_valid_o=1 iff head is COMMITTED; ex_* driven from head registers. ex_valid_o&&ex_ready_i frees head. KILLED head freed on the next edge with ex_valid_o=0.
- Full: count_o==DEPTH → issue_ready_o=0 for legal instrs, even if head frees this cycle (no same-cycle slot reuse).
- count_o = entries not FREE; simultaneous enqueue and free leave it unchanged.

## Timing
- Reset: queue empty, pointers 0, ex_valid_o=0, ex_op_o/ex_id_o/ex_rs*_o=0, count_o=0; issue_ready_o/accept follow combinational rules (ready=1 for legal instr with operands valid).
- issue_ready_o, issue_accept_o, issue_writeback_o combinational from issue inputs and count only.
- Minimum latency: issue+commit in cycle N → ex_valid_o=1 in N+1.
- Commit in N for an existing PENDING head → ex_valid_o in N+1.
- ex_* stable while ex_valid_o=1 && !ex_ready_i.
- Back-to-back dispatch: one op per cycle when heads are committed.
- Reset mid-operation: all entries dropped asynchronously; no dispatch of pre-reset entries.

## Test plan
- Reset, then BITREV (funct7 0, id 3, rs1=32'h0000_0001) with same-cycle commit kill=0 -> accept=1, ex_valid_o next cycle, ex_op_o=0, ex_id_o=3, ex_rs1_o=32'h1.
- Illegal instr 32'h0000_0013 -> issue_ready_o=1, accept=0, count_o stays 0.
- ENABLE_ROT=0, ROTLEFT -> accept=0; ENABLE_ROT=1, ROTRIGHT with issue_rs_valid_i=2'b01 -> issue_ready_o=0 until 2'b11.
- Issue ids 0..3 (DEPTH=4), no commits -> count_o=4, 5th legal issue ready=0; commit id 0, ex_ready_i=1 -> slot freed, ready=1 next cycle.
- Issue ids 1,2; commit 1 kill=1, 2 kill=0 -> id 1 never on ex_valid_o, id 2 dispatched.
- Commit with id 7 matching no pending entry -> ignored; hold ex_ready_i=0 3 cycles -> ex_* stable.
